apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: APB_Timer

---
 rtl/apb_timer_pkg.sv | 19 +
 rtl/timer_core.sv | 37 +++
 rtl/apb_timer.sv | 105 ++++++++++
 tb/tb_apb_timer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register map, control/status bit positions
// and data width.
package apb_timer_pkg;

    localparam int REG_W = 32;

    // Byte offsets; only bits [4:2] take part in decode.
    localparam logic [4:0] OFF_CR   = 5'h00;
    localparam logic [4:0] OFF_TCNT = 5'h04;
    localparam logic [4:0] OFF_PSC  = 5'h08;
    localparam logic [4:0] OFF_ARR  = 5'h0C;
    localparam logic [4:0] OFF_SR   = 5'h10;

    localparam int CR_EN  = 0;
    localparam int CR_CLR = 1;
    localparam int CR_IE  = 2;
    localparam int SR_UIF = 0;

endpackage

// File: rtl/timer_core.sv
// Prescaler and auto-reload up-counter; flags an update event when the counter reloads.
module timer_core
    import apb_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [REG_W-1:0] psc,
    input  logic [REG_W-1:0] arr,
    output logic             tick,
    output logic [REG_W-1:0] tcnt,
    output logic             uif_set
);

    logic [REG_W-1:0] psc_cnt;

    // A clear in the same cycle swallows the tick, so no reload and no flag either.
    assign tick    = en & ~clr & (psc_cnt == psc);
    assign uif_set = tick & (tcnt >= arr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt <= '0;
            tcnt    <= '0;
        end else if (clr) begin
            psc_cnt <= '0;
            tcnt    <= '0;
        end else if (tick) begin
            psc_cnt <= '0;
            tcnt    <= (tcnt >= arr) ? '0 : tcnt + 32'd1;
        end else if (en) begin
            psc_cnt <= psc_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB-attached timer: register decode, control/status registers and the
// zero-wait-state completer response around timer_core.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic              PSEL,
    input  logic [REG_W-1:0]  PWDATA,
    output logic [REG_W-1:0]  PRDATA,
    output logic              PREADY,
    output logic              irq
);

    logic [2:0]       idx;
    logic             wr;
    logic             rd_setup;
    logic             clr;
    logic             w1c;
    logic             en;
    logic             ie;
    logic             uif;
    logic [REG_W-1:0] psc;
    logic [REG_W-1:0] arr;
    logic [REG_W-1:0] tcnt;
    logic [REG_W-1:0] rdata;
    logic             tick;
    logic             uif_set;
    logic             unused_bits;

    assign idx         = PADDR[4:2];
    assign wr          = PSEL & PENABLE & PWRITE;
    assign rd_setup    = PSEL & ~PENABLE & ~PWRITE;
    assign clr         = wr & (idx == OFF_CR[4:2]) & PWDATA[CR_CLR];
    assign w1c         = wr & (idx == OFF_SR[4:2]) & PWDATA[SR_UIF];
    assign PREADY      = PSEL & PENABLE;
    assign unused_bits = ^{PADDR[ADDR_W-1:5], PADDR[1:0], tick};

    timer_core u_core (
        .clk     (PCLK),
        .rst     (PRESET),
        .en      (en),
        .clr     (clr),
        .psc     (psc),
        .arr     (arr),
        .tick    (tick),
        .tcnt    (tcnt),
        .uif_set (uif_set)
    );

    always_comb begin
        rdata = '0;
        case (idx)
            OFF_CR[4:2]: begin
                rdata[CR_EN] = en;
                rdata[CR_IE] = ie;
            end
            OFF_TCNT[4:2]: rdata         = tcnt;
            OFF_PSC[4:2]:  rdata         = psc;
            OFF_ARR[4:2]:  rdata         = arr;
            OFF_SR[4:2]:   rdata[SR_UIF] = uif;
            default:       rdata         = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en     <= 1'b0;
            ie     <= 1'b0;
            psc    <= '0;
            arr    <= '0;
            uif    <= 1'b0;
            irq    <= 1'b0;
            PRDATA <= '0;
        end else begin
            if (wr) begin
                case (idx)
                    OFF_CR[4:2]: begin
                        en <= PWDATA[CR_EN];
                        ie <= PWDATA[CR_IE];
                    end
                    OFF_PSC[4:2]: psc <= PWDATA;
                    OFF_ARR[4:2]: arr <= PWDATA;
                    default: ;
                endcase
            end
            // Hardware set beats a simultaneous software clear.
            if (uif_set) begin
                uif <= 1'b1;
            end else if (w1c) begin
                uif <= 1'b0;
            end
            irq <= uif & ie;
            if (rd_setup) begin
                PRDATA <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed scenarios plus random APB traffic, all checked
// against a cycle-level behavioural model of the timer.
module tb_apb_timer;

    localparam int ADDR_W = 12;

    logic              PCLK    = 1'b0;
    logic              PRESET  = 1'b1;
    logic [ADDR_W-1:0] PADDR   = '0;
    logic              PWRITE  = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PSEL    = 1'b0;
    logic [31:0]       PWDATA  = '0;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              irq;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        m_en, m_ie, m_uif, m_irq;
    logic [31:0] m_psc, m_arr, m_tcnt, m_psc_cnt, m_prdata;

    apb_timer #(.ADDR_W(ADDR_W)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_uif = 0; m_irq = 0;
        m_psc = 0; m_arr = 0; m_tcnt = 0; m_psc_cnt = 0; m_prdata = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return {29'd0, m_ie, 1'b0, m_en};
            3'd1:    return m_tcnt;
            3'd2:    return m_psc;
            3'd3:    return m_arr;
            3'd4:    return {31'd0, m_uif};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock using the bus values currently driven,
    // then let the DUT take the same edge and compare irq.
    task automatic cycle();
        logic       wr, rs, set;
        logic [2:0] off;
        wr  = PSEL && PENABLE && PWRITE;
        rs  = PSEL && !PENABLE && !PWRITE;
        off = PADDR[4:2];
        set = 0;
        if (rs) m_prdata = model_read(off);
        if (wr && off == 3'd0 && PWDATA[1]) begin
            m_psc_cnt = 0;
            m_tcnt    = 0;
        end else if (m_en) begin
            if (m_psc_cnt == m_psc) begin
                m_psc_cnt = 0;
                if (m_tcnt >= m_arr) begin
                    m_tcnt = 0;
                    set    = 1;
                end else begin
                    m_tcnt = m_tcnt + 1;
                end
            end else begin
                m_psc_cnt = m_psc_cnt + 1;
            end
        end
        m_irq = m_uif && m_ie;
        if (set) m_uif = 1;
        else if (wr && off == 3'd4 && PWDATA[0]) m_uif = 0;
        if (wr) begin
            case (off)
                3'd0: begin m_en = PWDATA[0]; m_ie = PWDATA[2]; end
                3'd2: m_psc = PWDATA;
                3'd3: m_arr = PWDATA;
                default: ;
            endcase
        end
        @(posedge PCLK);
        #1;
        chk("irq", irq, m_irq);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apb_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = addr; PWDATA = data;
        cycle();
        PENABLE = 1;
        #1;
        chk("pready_wr", PREADY, 1);
        cycle();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data);
        PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = addr;
        cycle();
        PENABLE = 1;
        #1;
        chk("pready_rd", PREADY, 1);
        chk("prdata", PRDATA, m_prdata);
        data = PRDATA;
        cycle();
        chk("prdata_hold", PRDATA, m_prdata);
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic rd_expect(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, d);
        chk(tag, d, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]       seq [6];
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data, d;
        logic [2:0]        off;
        int                k, op;

        seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};

        // reset and readback
        model_reset();
        #1;
        chk("rst_pready", PREADY, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_irq", irq, 0);
        @(posedge PCLK);
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 0;
        cycle();
        for (int a = 0; a < 8; a++) rd_expect("rst_read", ADDR_W'(a * 4), 32'd0);
        apb_write(12'h008, 32'h3);
        rd_expect("psc_readback", 12'h008, 32'h3);
        rd_expect("unmapped_14", 12'h014, 32'h0);
        apb_write(12'h004, 32'h1234);
        rd_expect("tcnt_ro", 12'h004, 32'h0);

        // period: PSC=1 ARR=4 -> UIF 10 cycles after EN, irq one later
        apb_write(12'h008, 32'd1);
        apb_write(12'h00C, 32'd4);
        apb_write(12'h000, 32'h5);
        k = 0;
        while (irq !== 1'b1 && k < 50) begin
            cycle();
            k++;
        end
        chk("period_irq_cycles", k, 11);
        apb_write(12'h000, 32'h7);
        for (int i = 0; i < 6; i++) rd_expect("tcnt_seq", 12'h004, seq[i]);

        // ARR=0, PSC=0: UIF every tick, TCNT pinned at 0; W1C loses to set
        apb_write(12'h000, 32'h4);
        apb_write(12'h010, 32'h1);
        apb_write(12'h008, 32'd0);
        apb_write(12'h00C, 32'd0);
        apb_write(12'h000, 32'h7);
        rd_expect("arr0_tcnt", 12'h004, 32'd0);
        rd_expect("arr0_tcnt2", 12'h004, 32'd0);
        apb_write(12'h010, 32'h1);
        rd_expect("race_uif", 12'h010, 32'h1);

        // W1C on an idle cycle clears UIF, irq follows a cycle later
        apb_write(12'h000, 32'h4);
        apb_write(12'h010, 32'h1);
        chk("w1c_irq_lag", irq, 1);
        cycle();
        chk("w1c_irq_fall", irq, 0);
        rd_expect("w1c_uif", 12'h010, 32'h0);

        // TCNT=9 then ARR=3 -> reload on next tick
        apb_write(12'h000, 32'h0);
        apb_write(12'h008, 32'd0);
        apb_write(12'h00C, 32'd100);
        apb_write(12'h000, 32'h3);
        idle(7);
        apb_write(12'h000, 32'h0);
        rd_expect("tcnt_9", 12'h004, 32'd9);
        rd_expect("uif_pre_arr", 12'h010, 32'h0);
        apb_write(12'h00C, 32'd3);
        apb_write(12'h000, 32'h1);
        idle(1);
        rd_expect("arr_shrink_tcnt", 12'h004, 32'd0);
        rd_expect("arr_shrink_uif", 12'h010, 32'h1);

        // CLR at TCNT=7
        apb_write(12'h00C, 32'd100);
        apb_write(12'h000, 32'h3);
        idle(5);
        apb_write(12'h000, 32'h0);
        rd_expect("tcnt_7", 12'h004, 32'd7);
        apb_write(12'h008, 32'd50);
        apb_write(12'h000, 32'h3);
        rd_expect("clr_tcnt", 12'h004, 32'd0);
        rd_expect("clr_cr", 12'h000, 32'h1);

        // EN=0 freezes TCNT at 5
        apb_write(12'h008, 32'd0);
        apb_write(12'h000, 32'h3);
        idle(3);
        apb_write(12'h000, 32'h0);
        rd_expect("freeze_5", 12'h004, 32'd5);
        idle(20);
        rd_expect("freeze_5_held", 12'h004, 32'd5);

        // reset mid-access aborts the write and clears everything
        apb_write(12'h008, 32'd3);
        apb_write(12'h00C, 32'd7);
        apb_write(12'h000, 32'h5);
        PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = 12'h00C; PWDATA = 32'h55;
        cycle();
        PENABLE = 1;
        #2;
        PRESET = 1;
        #1;
        chk("midrst_prdata", PRDATA, 0);
        chk("midrst_irq", irq, 0);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        #1;
        chk("midrst_pready", PREADY, 0);
        model_reset();
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 0;
        cycle();
        for (int a = 0; a < 5; a++) rd_expect("midrst_read", ADDR_W'(a * 4), 32'd0);
        idle(5);
        rd_expect("midrst_stopped", 12'h004, 32'd0);

        // random traffic against the model
        apb_write(12'h008, 32'd1);
        apb_write(12'h00C, 32'd3);
        apb_write(12'h000, 32'h7);
        for (int i = 0; i < 400; i++) begin
            op   = int'($urandom_range(0, 9));
            off  = 3'($urandom_range(0, 7));
            addr = ADDR_W'($urandom);
            addr[4:2] = off;
            addr[1:0] = 2'b00;
            case (off)
                3'd0:    data = 32'($urandom_range(0, 7));
                3'd2:    data = 32'($urandom_range(0, 3));
                3'd3:    data = 32'($urandom_range(0, 6));
                default: data = $urandom;
            endcase
            if (op < 4) apb_write(addr, data);
            else if (op < 8) apb_read(addr, d);
            else idle(int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
